// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: reset level, default widths,
// FSM state encodings and requester port indices.
`ifndef MEM_ARBITER_DEFS
`define MEM_ARBITER_DEFS
`define RstEnable      1'b1
`define RstDisable     1'b0
`define ARB_ADDR_WIDTH 32
`define ARB_DATA_WIDTH 32
`endif

package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } arb_state_e;

   localparam logic PORT_DATA  = 1'b0;
   localparam logic PORT_FETCH = 1'b1;

endpackage

// File: rtl/mem_arbiter_picker.sv
// Combinational winner selection between two requesters; the port named by
// pointer has priority when both request.
module arb_picker (
   input  logic [1:0] req,
   input  logic       pointer,
   output logic       grant_idx,
   output logic       valid
);

   logic w_other;

   assign w_other   = ~pointer;
   assign valid     = |req;
   assign grant_idx = req[pointer] ? pointer : w_other;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-port memory: IDLE -> ACCESS -> RESP, one access per two cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AddrWidth = `ARB_ADDR_WIDTH,
   parameter int DataWidth = `ARB_DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m0_req,
   input  logic                   m0_we,
   input  logic [AddrWidth-1:0]   m0_addr,
   input  logic [DataWidth/8-1:0] m0_byte_slct,
   input  logic [DataWidth-1:0]   m0_wdata,
   output logic [DataWidth-1:0]   m0_rdata,
   output logic                   m0_ack,
   output logic                   m0_stall,
   input  logic                   m1_req,
   input  logic                   m1_we,
   input  logic [AddrWidth-1:0]   m1_addr,
   input  logic [DataWidth/8-1:0] m1_byte_slct,
   input  logic [DataWidth-1:0]   m1_wdata,
   output logic [DataWidth-1:0]   m1_rdata,
   output logic                   m1_ack,
   output logic                   m1_stall,
   output logic                   mem_ce,
   output logic                   mem_we,
   output logic [AddrWidth-1:0]   mem_addr,
   output logic [DataWidth/8-1:0] mem_byte_slct,
   output logic [DataWidth-1:0]   mem_wdata,
   input  logic [DataWidth-1:0]   mem_rdata
);

   localparam int SelWidth = DataWidth / 8;

   arb_state_e            r_state;
   arb_state_e            w_state_next;
   logic                  r_port;
   logic                  r_we;
   logic [AddrWidth-1:0]  r_addr;
   logic [SelWidth-1:0]   r_bsel;
   logic [DataWidth-1:0]  r_wdata;
   logic [DataWidth-1:0]  r_rdata0;
   logic [DataWidth-1:0]  r_rdata1;
   logic [1:0]            w_req;
   logic                  w_pointer;
   logic                  w_grant;
   logic                  w_valid;
   logic                  w_take;

   assign w_req = {m1_req, m0_req};
   // IDLE and RESP are both decision points; ACCESS never accepts a new request.
   assign w_take = (r_state != ST_ACCESS) && w_valid;

   arb_picker u_picker (
      .req       (w_req),
      .pointer   (w_pointer),
      .grant_idx (w_grant),
      .valid     (w_valid)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic r_pointer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == `RstEnable) begin
         r_pointer <= PORT_DATA;
      end else if (w_take) begin
         r_pointer <= ~w_grant;
      end
   end

   assign w_pointer = r_pointer;
`else
   assign w_pointer = PORT_DATA;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst == `RstEnable) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = ST_IDLE;
      mem_ce        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_byte_slct = '0;
      mem_wdata     = '0;
      m0_ack        = 1'b0;
      m1_ack        = 1'b0;
      case (r_state)
         ST_ACCESS: begin
            w_state_next  = ST_RESP;
            mem_ce        = 1'b1;
            mem_we        = r_we;
            mem_addr      = r_addr;
            mem_byte_slct = r_bsel;
            mem_wdata     = r_wdata;
         end
         ST_RESP: begin
            w_state_next = w_valid ? ST_ACCESS : ST_IDLE;
            m0_ack       = (r_port == PORT_DATA);
            m1_ack       = (r_port == PORT_FETCH);
         end
         default: begin
            w_state_next = w_valid ? ST_ACCESS : ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == `RstEnable) begin
         r_port   <= PORT_DATA;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_bsel   <= '0;
         r_wdata  <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (w_take) begin
            r_port  <= w_grant;
            r_we    <= (w_grant == PORT_FETCH) ? m1_we        : m0_we;
            r_addr  <= (w_grant == PORT_FETCH) ? m1_addr      : m0_addr;
            r_bsel  <= (w_grant == PORT_FETCH) ? m1_byte_slct : m0_byte_slct;
            r_wdata <= (w_grant == PORT_FETCH) ? m1_wdata     : m0_wdata;
         end
         if (r_state == ST_ACCESS && !r_we) begin
            if (r_port == PORT_FETCH) begin
               r_rdata1 <= mem_rdata;
            end else begin
               r_rdata0 <= mem_rdata;
            end
         end
      end
   end

   assign m0_rdata = r_rdata0;
   assign m1_rdata = r_rdata1;
   assign m0_stall = m0_req & ~m0_ack;
   assign m1_stall = m1_req & ~m1_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, per-port scoreboards, directed scenarios.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m0_ack, m0_stall;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_byte_slct;
   logic        m1_req, m1_we, m1_ack, m1_stall;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_byte_slct;
   logic        mem_ce, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_byte_slct;

   mem_arbiter #(.AddrWidth(32), .DataWidth(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byte_slct(m0_byte_slct),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byte_slct(m1_byte_slct),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_stall(m1_stall),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byte_slct(mem_byte_slct),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h3C00FFFF;
      return 32'h1000_0000 + i * 32'h0001_0203;
   endfunction

   logic [31:0] mem [0:255];
   bit          mem_init_done;

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_init_done <= 1'b1;
      end else if (mem_ce && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_byte_slct[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   logic [31:0] ref_mem [0:255];
   logic [31:0] exp_rdata [2];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   int n_tests, n_fail;
   int ce_cnt, we_cnt, ack0_cnt, ack1_cnt;
   logic [31:0] last_ce_addr;
   int lat0, lat1, snap_ce, snap_we, snap_ack0, snap_ack1, n_m0;
   bit m0_stop;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
   endtask

   // One transaction: drive at a negedge, optionally drop req after drop_after
   // cycles, and release req as soon as ack is seen. lat = cycles to ack.
   task automatic do_req(input int port, input logic we, input logic [31:0] addr,
                         input logic [3:0] bsel, input logic [31:0] wdata,
                         input int drop_after, output int lat);
      logic        ack, stall;
      logic [31:0] exp;
      int          n;
      @(negedge clk);
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (bsel[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
         exp = exp_rdata[port];
      end else begin
         exp = ref_mem[addr[9:2]];
         exp_rdata[port] = exp;
      end
      if (port == 0) begin
         q0.push_back(exp);
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_byte_slct = bsel; m0_wdata = wdata;
      end else begin
         q1.push_back(exp);
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_byte_slct = bsel; m1_wdata = wdata;
      end
      lat = -1;
      n = 0;
      ack = 1'b0;
      while (lat < 0 && n < 40) begin
         @(negedge clk);
         n++;
         ack   = (port == 0) ? m0_ack : m1_ack;
         stall = (port == 0) ? m0_stall : m1_stall;
         if (n == 1) check($sformatf("m%0d_stall_pending", port), stall, 1);
         if (ack) begin
            lat = n;
            check($sformatf("m%0d_stall_at_ack", port), stall, 0);
         end
         if (ack || n == drop_after) begin
            if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
         end
      end
      if (lat < 0) begin
         check($sformatf("m%0d_ack_timeout", port), ack, 1);
         if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_byte_slct = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_byte_slct = 0; m1_wdata = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;

      // Monitor: counts memory activity, checks idle bus, pops scoreboards on ack.
      fork
         forever begin
            @(negedge clk);
            if (mem_ce) begin
               ce_cnt++;
               last_ce_addr = mem_addr;
            end else begin
               check("mem_idle_zero", {31'd0, mem_we} | mem_addr | {28'd0, mem_byte_slct} | mem_wdata, 0);
            end
            if (mem_we) we_cnt++;
            if (m0_ack) begin
               ack0_cnt++;
               if (q0.size() == 0) check("m0_ack_unexpected", m0_ack, 0);
               else check("m0_rdata", m0_rdata, q0.pop_front());
            end
            if (m1_ack) begin
               ack1_cnt++;
               if (q1.size() == 0) check("m1_ack_unexpected", m1_ack, 0);
               else check("m1_rdata", m1_rdata, q1.pop_front());
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_ce", mem_ce, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_m0_ack", m0_ack, 0);
      check("rst_m1_ack", m1_ack, 0);
      check("rst_m0_rdata", m0_rdata, 0);
      check("rst_m1_rdata", m1_rdata, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single read on the fetch port
      snap_ce = ce_cnt; snap_we = we_cnt;
      do_req(1, 1'b0, 32'h10, 4'hF, 32'h0, 0, lat1);
      check("rd_latency", lat1, 2);
      repeat (2) @(negedge clk);
      check("rd_ce_cycles", ce_cnt - snap_ce, 1);
      check("rd_we_cycles", we_cnt - snap_we, 0);
      check("rd_mem_addr", last_ce_addr, 32'h10);
      check("rd_m1_rdata", m1_rdata, 32'h3C00FFFF);

      // Write then read on the data port, plus a single-lane write
      snap_ce = ce_cnt; snap_we = we_cnt;
      do_req(0, 1'b1, 32'h20, 4'b1111, 32'hDEADBEEF, 0, lat0);
      check("wr_latency", lat0, 2);
      repeat (2) @(negedge clk);
      check("wr_we_cycles", we_cnt - snap_we, 1);
      check("wr_ce_cycles", ce_cnt - snap_ce, 1);
      snap_ce = ce_cnt; snap_we = we_cnt;
      do_req(0, 1'b0, 32'h20, 4'b1111, 32'h0, 0, lat0);
      repeat (2) @(negedge clk);
      check("rd_after_wr_we", we_cnt - snap_we, 0);
      check("rd_after_wr_ce", ce_cnt - snap_ce, 1);
      check("rd_after_wr_data", m0_rdata, 32'hDEADBEEF);
      do_req(0, 1'b1, 32'h20, 4'b0100, 32'h00AB0000, 0, lat0);
      do_req(0, 1'b0, 32'h20, 4'b1111, 32'h0, 0, lat0);
      repeat (2) @(negedge clk);
      check("byte_lane_data", m0_rdata, 32'hDEABBEEF);
      check("m1_rdata_held", m1_rdata, 32'h3C00FFFF);

      // Conflict from a freshly reset pointer: data port first, fetch two cycles later
      apply_reset();
      fork
         do_req(0, 1'b0, 32'h30, 4'hF, 32'h0, 0, lat0);
         do_req(1, 1'b0, 32'h40, 4'hF, 32'h0, 0, lat1);
      join
      check("conflict1_m0_lat", lat0, 2);
      check("conflict1_m1_lat", lat1, 4);
      // A lone data access, then a second conflict
      do_req(0, 1'b0, 32'h34, 4'hF, 32'h0, 0, lat0);
      fork
         do_req(0, 1'b0, 32'h38, 4'hF, 32'h0, 0, lat0);
         do_req(1, 1'b0, 32'h48, 4'hF, 32'h0, 0, lat1);
      join
`ifdef ARB_ROUND_ROBIN_EN
      check("conflict2_m1_lat", lat1, 2);
      check("conflict2_m0_lat", lat0, 4);
`else
      check("conflict2_m0_lat", lat0, 2);
      check("conflict2_m1_lat", lat1, 4);
`endif

      // Starvation: data port requests back to back, fetch port asks once
      @(negedge clk);
      m0_stop = 1'b0;
      fork
         begin
            @(negedge clk);
            exp_rdata[0] = ref_mem[20];
            q0.push_back(ref_mem[20]);
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h50; m0_byte_slct = 4'hF;
            n_m0 = 0;
            while (m0_req && n_m0 < 100) begin
               @(negedge clk);
               n_m0++;
               if (m0_ack) begin
                  if (m0_stop) m0_req = 1'b0;
                  else q0.push_back(ref_mem[20]);
               end
            end
         end
         begin
            repeat (3) @(negedge clk);
            do_req(1, 1'b0, 32'h60, 4'hF, 32'h0, 0, lat1);
         end
         begin
            repeat (12) @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            check("starve_m1_stall", m1_stall, 0);
`else
            check("starve_m1_stall", m1_stall, 1);
`endif
            m0_stop = 1'b1;
         end
      join
`ifdef ARB_ROUND_ROBIN_EN
      check("starve_rr_m1_lat", lat1, 2 + 1);
`else
      check("starve_fixed_m1_lat", lat1, 11);
`endif
      check("starve_m0_dropped", m0_req, 0);

      // Reset during an ACCESS carrying a write
      repeat (2) @(negedge clk);
      snap_ack1 = ack1_cnt;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_byte_slct = 4'hF; m1_wdata = 32'h11111111;
      @(posedge clk);
      #1;
      check("abort_ce_before", mem_ce, 1);
      check("abort_we_before", mem_we, 1);
      #2 rst = 1'b1;
      #1;
      check("abort_ce_async", mem_ce, 0);
      check("abort_we_async", mem_we, 0);
      m1_req = 1'b0;
      m1_we  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      repeat (3) @(negedge clk);
      check("abort_no_ack", ack1_cnt - snap_ack1, 0);
      check("abort_rdata_cleared", m1_rdata, 0);
      do_req(1, 1'b0, 32'h44, 4'hF, 32'h0, 0, lat1);
      check("abort_recover_lat", lat1, 2);
      @(negedge clk);
      check("abort_write_dropped", m1_rdata, init_word(17));

      // Early drop: fetch port releases req during ACCESS
      @(negedge clk);
      snap_ce = ce_cnt; snap_ack1 = ack1_cnt;
      do_req(1, 1'b0, 32'h70, 4'hF, 32'h0, 1, lat1);
      check("drop_latency", lat1, 2);
      repeat (4) @(negedge clk);
      check("drop_ce_cycles", ce_cnt - snap_ce, 1);
      check("drop_ack_count", ack1_cnt - snap_ack1, 1);

      repeat (2) @(negedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
